// File: rtl/kernel_ad_ctrl.sv
// kernel_ad_ctrl: Avalon-MM slave for AD converter control lines.
// Optional OUTSET/OUTCLR ports: define KERNEL_AD_CTRL_BITSET_EN.
module kernel_ad_ctrl #(
  parameter int WIDTH   = 4,
  parameter int PW_BITS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             ad_start,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_PWIDTH = 3'd1;
  localparam logic [2:0] A_CMD    = 3'd2;
  localparam logic [2:0] A_COUNT  = 3'd3;
`ifdef KERNEL_AD_CTRL_BITSET_EN
  localparam logic [2:0] A_OUTSET = 3'd4;
  localparam logic [2:0] A_OUTCLR = 3'd5;
`endif

  state_t             state;
  state_t             next_state;
  logic [PW_BITS-1:0] cnt;
  logic [PW_BITS-1:0] next_cnt;
  logic [PW_BITS-1:0] pwidth;
  logic [WIDTH-1:0]   data;
  logic [15:0]        count;
  logic               wr;
  logic               start_req;
  logic               accept;
  logic [31:0]        rd_mux;
  logic               unused_wd;

  assign wr        = chipselect & ~write_n;
  assign start_req = wr && (address == A_CMD) && writedata[0];
  assign unused_wd = ^writedata;

  assign ad_start = (state == PULSE);
  assign busy     = (state == PULSE);
  assign out_port = data;

  // Strobe state and width down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state: latch width on accept, count down while pulsing.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_req) begin
          next_state = PULSE;
          accept     = 1'b1;
          next_cnt   = (pwidth == '0) ? PW_BITS'(1) : pwidth;
        end
      end
      PULSE: begin
        if (cnt <= PW_BITS'(1)) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt - PW_BITS'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // DATA register, with optional bit set/clear ports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
    end else if (wr) begin
      if (address == A_DATA)
        data <= writedata[WIDTH-1:0];
`ifdef KERNEL_AD_CTRL_BITSET_EN
      else if (address == A_OUTSET)
        data <= data | writedata[WIDTH-1:0];
      else if (address == A_OUTCLR)
        data <= data & ~writedata[WIDTH-1:0];
`endif
    end
  end

  // Pulse-width register; resets to a one-cycle strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pwidth <= PW_BITS'(1);
    else if (wr && address == A_PWIDTH)
      pwidth <= writedata[PW_BITS-1:0];
  end

  // Accepted-strobe counter; a write to it clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (wr && address == A_COUNT)
      count <= '0;
    else if (accept)
      count <= count + 16'd1;
  end

  // Read mux; unused bits and addresses read zero.
  always_comb begin
    rd_mux = '0;
    unique case (address)
      A_DATA:   rd_mux = {{(32-WIDTH){1'b0}}, data};
      A_PWIDTH: rd_mux = {{(32-PW_BITS){1'b0}}, pwidth};
      A_CMD:    rd_mux = {31'b0, busy};
      A_COUNT:  rd_mux = {16'b0, count};
      default:  rd_mux = '0;
    endcase
  end

  // Registered read data, updated every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else
      readdata <= rd_mux;
  end

endmodule

// File: tb/tb_kernel_ad_ctrl.sv
// tb_kernel_ad_ctrl: directed plus random checks of kernel_ad_ctrl
// against a cycle-level behavioural model.
module tb_kernel_ad_ctrl;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;
  logic        ad_start;
  logic        busy;

  int tests;
  int fails;

  // model state
  logic [3:0]  m_data;
  logic [15:0] m_pw;
  logic [15:0] m_count;
  int          m_rem;
  logic [31:0] m_rd;

  kernel_ad_ctrl #(.WIDTH(4), .PW_BITS(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .ad_start(ad_start),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_pw    = 16'd1;
    m_count = '0;
    m_rem   = 0;
    m_rd    = '0;
  endtask

  // One clock edge of the register map, from the bus values sampled.
  task automatic model_step();
    logic wr;
    wr = chipselect & ~write_n;
    case (address)
      3'd0: m_rd = {28'b0, m_data};
      3'd1: m_rd = {16'b0, m_pw};
      3'd2: m_rd = {31'b0, m_rem > 0};
      3'd3: m_rd = {16'b0, m_count};
      default: m_rd = '0;
    endcase
    if (m_rem > 0) begin
      m_rem = m_rem - 1;
    end else if (wr && address == 3'd2 && writedata[0]) begin
      m_rem   = (m_pw == 0) ? 1 : int'(m_pw);
      m_count = m_count + 16'd1;
    end
    if (wr) begin
      case (address)
        3'd0: m_data = writedata[3:0];
        3'd1: m_pw = writedata[15:0];
        3'd3: m_count = '0;
`ifdef KERNEL_AD_CTRL_BITSET_EN
        3'd4: m_data = m_data | writedata[3:0];
        3'd5: m_data = m_data & ~writedata[3:0];
`endif
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    chk("readdata", readdata, m_rd);
    chk("out_port", {28'b0, out_port}, {28'b0, m_data});
    chk("ad_start", {31'b0, ad_start}, {31'b0, m_rem > 0});
    chk("busy", {31'b0, busy}, {31'b0, m_rem > 0});
  endtask

  // Drive one bus cycle, step the model on the edge, check after it.
  task automatic cyc(input logic [2:0] a, input logic w,
                     input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = ~w;
    writedata  = d;
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle();
    cyc(3'd0, 1'b0, 32'h0);
  endtask

  int highs;

  initial begin
    tests      = 0;
    fails      = 0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    model_reset();
    #1;
    chk("rst_out_port", {28'b0, out_port}, 32'h0);
    chk("rst_ad_start", {31'b0, ad_start}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    #11 reset_n = 1'b1;

    for (int a = 0; a < 8; a++) cyc(3'(a), 1'b0, 32'h0);
    cyc(3'd1, 1'b0, 32'h0);
    chk("rst_pwidth", readdata, 32'h1);
    cyc(3'd3, 1'b0, 32'h0);
    chk("rst_count", readdata, 32'h0);

    cyc(3'd0, 1'b1, 32'hA);
    chk("data_out", {28'b0, out_port}, 32'hA);
    cyc(3'd0, 1'b0, 32'h0);
    chk("data_rd", readdata, 32'hA);

    cyc(3'd1, 1'b1, 32'd3);
    cyc(3'd2, 1'b1, 32'd1);
    chk("strobe_n1", {31'b0, ad_start}, 32'h1);
    cyc(3'd2, 1'b1, 32'd1);
    chk("cmd_rd_busy", readdata, 32'h1);
    cyc(3'd1, 1'b1, 32'd5);
    chk("strobe_n3", {31'b0, ad_start}, 32'h1);
    cyc(3'd3, 1'b0, 32'h0);
    chk("strobe_n4", {31'b0, ad_start}, 32'h0);
    chk("count1", readdata, 32'h1);

    cyc(3'd2, 1'b1, 32'd1);
    highs = 0;
    for (int i = 0; i < 20 && ad_start; i++) begin
      highs++;
      idle();
    end
    chk("width5", 32'(highs), 32'd5);
    cyc(3'd3, 1'b0, 32'h0);
    chk("count2", readdata, 32'h2);

    cyc(3'd1, 1'b1, 32'd0);
    cyc(3'd2, 1'b1, 32'd1);
    chk("pw0_hi", {31'b0, ad_start}, 32'h1);
    idle();
    chk("pw0_lo", {31'b0, ad_start}, 32'h0);
    cyc(3'd3, 1'b1, 32'h1234);
    cyc(3'd3, 1'b0, 32'h0);
    chk("count_clr", readdata, 32'h0);

    cyc(3'd0, 1'b1, 32'h5);
    cyc(3'd4, 1'b1, 32'h2);
`ifdef KERNEL_AD_CTRL_BITSET_EN
    chk("outset", {28'b0, out_port}, 32'h7);
`else
    chk("outset", {28'b0, out_port}, 32'h5);
`endif
    cyc(3'd5, 1'b1, 32'h4);
`ifdef KERNEL_AD_CTRL_BITSET_EN
    chk("outclr", {28'b0, out_port}, 32'h3);
`else
    chk("outclr", {28'b0, out_port}, 32'h5);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = (a == 3'd1) ? 32'($urandom_range(0, 7)) : $urandom;
      address    = a;
      chipselect = 1'($urandom);
      write_n    = 1'($urandom);
      writedata  = d;
      @(posedge clk);
      model_step();
      #1;
      compare();
    end

    cyc(3'd1, 1'b1, 32'd4);
    cyc(3'd2, 1'b1, 32'd1);
    idle();
    chk("pre_rst_hi", {31'b0, ad_start}, 32'h1);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_mid_start", {31'b0, ad_start}, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_out", {28'b0, out_port}, 32'h0);
    chk("rst_mid_rd", readdata, 32'h0);
    model_reset();
    #2 reset_n = 1'b1;
    cyc(3'd1, 1'b0, 32'h0);
    cyc(3'd3, 1'b0, 32'h0);
    chk("post_rst_pw", {31'b0, ad_start}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
